// File: rtl/onchip_mem_pkg.sv
// Shared types for the two-requester on-chip memory arbiter.
package onchip_mem_pkg;

    // Arbiter FSM: free round-robin arbitration, or one requester holding the RAM.
    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Index of a requester (0 or 1).
    typedef logic req_idx_t;

    // After reset requester 1 counts as last granted, so requester 0 wins the first tie.
    localparam req_idx_t RESET_LAST_GRANT = 1'b1;

    // Convert a one-hot two-bit grant into a requester index.
    function automatic req_idx_t onehot_to_idx(input logic [1:0] onehot);
        return onehot[1];
    endfunction

endpackage

// File: rtl/onchip_mem_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and a single-port RAM.
interface onchip_mem_arbiter_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   m0_address;
    logic [DATA_W/8-1:0] m0_byteenable;
    logic                m0_read;
    logic                m0_write;
    logic [DATA_W-1:0]   m0_writedata;
    logic                m0_lock;
    logic                m0_waitrequest;
    logic [DATA_W-1:0]   m0_readdata;
    logic                m0_readdatavalid;

    logic [ADDR_W-1:0]   m1_address;
    logic [DATA_W/8-1:0] m1_byteenable;
    logic                m1_read;
    logic                m1_write;
    logic [DATA_W-1:0]   m1_writedata;
    logic                m1_lock;
    logic                m1_waitrequest;
    logic [DATA_W-1:0]   m1_readdata;
    logic                m1_readdatavalid;

    logic [ADDR_W-1:0]   mem_address;
    logic [DATA_W/8-1:0] mem_byteenable;
    logic [DATA_W-1:0]   mem_writedata;
    logic                mem_chipselect;
    logic                mem_write;
    logic                mem_clken;
    logic [DATA_W-1:0]   mem_readdata;

    // Arbiter view: takes requester commands and RAM read data, drives everything else.
    modport slave (
        input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata, m0_lock,
        output m0_waitrequest, m0_readdata, m0_readdatavalid,
        input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata, m1_lock,
        output m1_waitrequest, m1_readdata, m1_readdatavalid,
        output mem_address, mem_byteenable, mem_writedata, mem_chipselect, mem_write, mem_clken,
        input  mem_readdata
    );

    // Environment view: requesters plus the RAM that sits behind the arbiter.
    modport master (
        output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata, m0_lock,
        input  m0_waitrequest, m0_readdata, m0_readdatavalid,
        output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata, m1_lock,
        input  m1_waitrequest, m1_readdata, m1_readdatavalid,
        input  mem_address, mem_byteenable, mem_writedata, mem_chipselect, mem_write, mem_clken,
        output mem_readdata
    );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin tie-break: a lone requester wins, on a tie the one not granted last wins.
module rr_pick2
    import onchip_mem_pkg::*;
(
    input  logic [1:0] req,
    input  req_idx_t   last,
    output logic [1:0] grant
);

    // Pure combinational pick; grant is one-hot or zero.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (last == 1'b1) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Arbiter sharing one single-port on-chip RAM between two requesters, with lock and freeze.
module onchip_mem_arbiter
    import onchip_mem_pkg::*;
#(
    parameter int ADDR_W   = 2,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 freeze,
    onchip_mem_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);
    localparam logic [CNT_W-1:0] LOCK_ONE_C = CNT_W'(1);

    arb_state_e       state_q, state_d;
    req_idx_t         last_grant_q, last_grant_d;
    req_idx_t         owner_q, owner_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             rd_pend_q, rd_pend_d;
    req_idx_t         rd_who_q, rd_who_d;

    logic [1:0] req;
    logic [1:0] lock_in;
    logic [1:0] rd_in;
    logic [1:0] wr_in;
    logic [1:0] rr_grant;
    logic [1:0] grant;
    logic       accepted;
    req_idx_t   acc_idx;
    logic       rd_valid;

    // Gather per-requester command bits into small vectors for indexing.
    always_comb begin
        rd_in   = {bus.m1_read, bus.m0_read};
        wr_in   = {bus.m1_write, bus.m0_write};
        lock_in = {bus.m1_lock, bus.m0_lock};
        req     = rd_in | wr_in;
    end

    rr_pick2 u_pick (
        .req   (req),
        .last  (last_grant_q),
        .grant (rr_grant)
    );

    // Decide who owns the RAM this cycle; nobody while in reset or frozen, only the owner while locked.
    always_comb begin
        grant = 2'b00;
        if (!reset && !freeze) begin
            if (state_q == ARB) begin
                grant = rr_grant;
            end else if (req[owner_q]) begin
                grant[owner_q] = 1'b1;
            end
        end
        accepted = |grant;
        acc_idx  = onehot_to_idx(grant);
    end

    // Steer the granted requester onto the RAM port; idle port is driven to zero.
    always_comb begin
        bus.m0_waitrequest = ~grant[0];
        bus.m1_waitrequest = ~grant[1];
        bus.mem_address    = '0;
        bus.mem_byteenable = '0;
        bus.mem_writedata  = '0;
        bus.mem_chipselect = accepted;
        bus.mem_write      = accepted & wr_in[acc_idx];
        bus.mem_clken      = reset | ~freeze;
        if (accepted) begin
            if (acc_idx == 1'b1) begin
                bus.mem_address    = bus.m1_address;
                bus.mem_byteenable = bus.m1_byteenable;
                bus.mem_writedata  = bus.m1_writedata;
            end else begin
                bus.mem_address    = bus.m0_address;
                bus.mem_byteenable = bus.m0_byteenable;
                bus.mem_writedata  = bus.m0_writedata;
            end
        end
    end

    // Return RAM read data one cycle after acceptance to whoever issued the read; zero otherwise.
    always_comb begin
        rd_valid             = rd_pend_q & ~reset;
        bus.m0_readdatavalid = rd_valid & (rd_who_q == 1'b0);
        bus.m1_readdatavalid = rd_valid & (rd_who_q == 1'b1);
        bus.m0_readdata      = bus.m0_readdatavalid ? bus.mem_readdata : '0;
        bus.m1_readdata      = bus.m1_readdatavalid ? bus.mem_readdata : '0;
    end

    // Next-state logic: round-robin history, lock entry/exit with a saturating hold counter, read tracking.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        lock_cnt_d   = lock_cnt_q;
        rd_pend_d    = accepted & rd_in[acc_idx] & ~wr_in[acc_idx];
        rd_who_d     = acc_idx;
        if (!freeze) begin
            if (accepted) begin
                last_grant_d = acc_idx;
            end
            case (state_q)
                ARB: begin
                    if (accepted && lock_in[acc_idx]) begin
                        state_d    = LOCKED;
                        owner_d    = acc_idx;
                        lock_cnt_d = LOCK_ONE_C;
                    end
                end
                LOCKED: begin
                    lock_cnt_d = (lock_cnt_q >= LOCK_MAX_C) ? LOCK_MAX_C : lock_cnt_q + 1'b1;
                    if (accepted && !lock_in[owner_q]) begin
                        state_d = ARB;
                    end else if (!req[owner_q] && !lock_in[owner_q]) begin
                        state_d = ARB;
                    end else if (lock_cnt_d == LOCK_MAX_C) begin
                        state_d = ARB;
                    end
                end
                default: begin
                    state_d = ARB;
                end
            endcase
        end
    end

    // State register with synchronous reset; a read in flight when reset hits is discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARB;
            last_grant_q <= RESET_LAST_GRANT;
            owner_q      <= 1'b0;
            lock_cnt_q   <= '0;
            rd_pend_q    <= 1'b0;
            rd_who_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            lock_cnt_q   <= lock_cnt_d;
            rd_pend_q    <= rd_pend_d;
            rd_who_q     <= rd_who_d;
        end
    end

endmodule
